// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared widths, packet field offsets and types for the CMS trace stream
package continuous_monitoring_system_pkg;

    localparam int XLEN                                = 32;
    localparam int RISC_V_INSTRUCTION_WIDTH            = 32;
    localparam int CLK_COUNTER_WIDTH                   = 32;
    localparam int NO_OF_PERFORMANCE_EVENTS            = 4;
    localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 8;
    localparam int PERF_FIELD_WIDTH = NO_OF_PERFORMANCE_EVENTS * PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;

    // Offsets are shared with the producer: counters at the LSB end, instr at the MSB end.
    localparam int PERF_LOCATION              = 0;
    localparam int PC_LOCATION                = PERF_LOCATION + PERF_FIELD_WIDTH;
    localparam int CLK_COUNTER_DELTA_LOCATION = PC_LOCATION + XLEN;
    localparam int INSTR_LOCATION             = CLK_COUNTER_DELTA_LOCATION + CLK_COUNTER_WIDTH;
    localparam int AXI_DATA_WIDTH             = INSTR_LOCATION + RISC_V_INSTRUCTION_WIDTH;

    typedef struct packed {
        logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
        logic [CLK_COUNTER_WIDTH-1:0]        delta;
        logic [XLEN-1:0]                     pc;
        logic [0:NO_OF_PERFORMANCE_EVENTS-1][PERFORMANCE_EVENT_MOD_COUNTER_WIDTH-1:0] counters;
    } trace_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } decoder_state_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry fall-through stream buffer with registered tready
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             ready_r;
    logic             empty;
    logic             push;
    logic             store;
    logic             pop;

    assign empty    = (count == 2'd0);
    assign push     = s_tvalid & ready_r;
    assign s_tready = ready_r;

    // When empty, a beat bypasses storage so the consumer sees it on the same edge.
    assign m_tvalid = empty ? push : 1'b1;
    assign m_tdata  = empty ? s_tdata : mem[rd_ptr];
    assign store    = push & ~(empty & m_tready);
    assign pop      = ~empty & m_tready;

    always_comb begin
        count_next = count + {1'b0, store} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            count   <= count_next;
            ready_r <= (count_next != 2'd2);
            if (store) wr_ptr <= ~wr_ptr;
            if (pop)   rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= s_tdata;
    end

endmodule

// File: rtl/trace_pkt_decoder.sv
// rtl/trace_pkt_decoder.sv - CMS trace packet decoder with timestamp rebuild and statistics
// optional: CMS_DECODER_PERF_TOTALS_EN enables per-event 32-bit saturating totals
module trace_pkt_decoder
    import continuous_monitoring_system_pkg::*;
#(
    parameter int DATA_WIDTH   = AXI_DATA_WIDTH,
    parameter int NO_OF_EVENTS = NO_OF_PERFORMANCE_EVENTS,
    parameter int EVT_W        = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
    parameter int TS_W         = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                S_AXIS_tvalid,
    output logic                                S_AXIS_tready,
    input  logic [DATA_WIDTH-1:0]               S_AXIS_tdata,
    input  logic                                S_AXIS_tlast,
    input  logic                                clear,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RISC_V_INSTRUCTION_WIDTH-1:0] out_instr,
    output logic [XLEN-1:0]                     out_pc,
    output logic [CLK_COUNTER_WIDTH-1:0]        out_delta,
    output logic [TS_W-1:0]                     out_timestamp,
    output logic [NO_OF_EVENTS*EVT_W-1:0]       out_perf,
    output logic                                out_first,
    output logic                                out_last,
    output logic [31:0]                         pkt_count,
    output logic [15:0]                         trace_count,
    output logic                                err_zero_delta,
    output logic [NO_OF_EVENTS*32-1:0]          perf_total
);

    logic                  sk_valid;
    logic                  sk_ready;
    logic [DATA_WIDTH:0]   sk_data;
    logic                  load;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  beat_last;
    logic [CLK_COUNTER_WIDTH-1:0] beat_delta;
    logic                  beat_first;
    logic [TS_W-1:0]       ts_r;
    logic [TS_W-1:0]       ts_next;
    logic [31:0]           pkt_base;
    logic [15:0]           trace_base;
    decoder_state_t        state;

    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (S_AXIS_tvalid),
        .s_tready (S_AXIS_tready),
        .s_tdata  ({S_AXIS_tlast, S_AXIS_tdata}),
        .m_tvalid (sk_valid),
        .m_tready (sk_ready),
        .m_tdata  (sk_data)
    );

    assign sk_ready = ~out_valid | out_ready;
    assign load     = sk_valid & sk_ready;

    // A clear coinciding with a load is applied first, so the load restarts everything.
    always_comb begin
        beat_data  = sk_data[DATA_WIDTH-1:0];
        beat_last  = sk_data[DATA_WIDTH];
        beat_delta = beat_data[CLK_COUNTER_DELTA_LOCATION +: CLK_COUNTER_WIDTH];
        beat_first = clear | (state != RUN);
        ts_next    = (beat_first ? '0 : ts_r) + TS_W'(beat_delta);
        pkt_base   = clear ? 32'd0 : pkt_count;
        trace_base = clear ? 16'd0 : trace_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ts_r           <= '0;
            pkt_count      <= 32'd0;
            trace_count    <= 16'd0;
            err_zero_delta <= 1'b0;
        end else if (load) begin
            state          <= beat_last ? DONE : RUN;
            ts_r           <= ts_next;
            pkt_count      <= sat_add32(pkt_base, 32'd1);
            trace_count    <= trace_base + {15'd0, beat_last};
            err_zero_delta <= (err_zero_delta & ~clear) | (beat_delta == '0);
        end else if (clear) begin
            state          <= IDLE;
            ts_r           <= '0;
            pkt_count      <= 32'd0;
            trace_count    <= 16'd0;
            err_zero_delta <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_instr     <= '0;
            out_pc        <= '0;
            out_delta     <= '0;
            out_timestamp <= '0;
            out_perf      <= '0;
            out_first     <= 1'b0;
            out_last      <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_instr     <= beat_data[INSTR_LOCATION +: RISC_V_INSTRUCTION_WIDTH];
            out_pc        <= beat_data[PC_LOCATION +: XLEN];
            out_delta     <= beat_delta;
            out_timestamp <= ts_next;
            out_perf      <= beat_data[PERF_LOCATION +: NO_OF_EVENTS*EVT_W];
            out_first     <= beat_first;
            out_last      <= beat_last;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

`ifdef CMS_DECODER_PERF_TOTALS_EN
    // Event 0 sits in the most significant slice, matching packet order.
    for (genvar i = 0; i < NO_OF_EVENTS; i++) begin : g_perf
        logic [EVT_W-1:0] cnt;
        logic [31:0]      total_q;
        logic [31:0]      base;

        assign cnt  = beat_data[PERF_LOCATION + (NO_OF_EVENTS-1-i)*EVT_W +: EVT_W];
        assign base = beat_first ? 32'd0 : total_q;
        assign perf_total[(NO_OF_EVENTS-1-i)*32 +: 32] = total_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                total_q <= 32'd0;
            end else if (load) begin
                total_q <= sat_add32(base, 32'(cnt));
            end else if (clear) begin
                total_q <= 32'd0;
            end
        end
    end
`else
    assign perf_total = '0;
`endif

endmodule
